dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Multi-cycle data-memory responder; the target end of the pipeline's M-stage load/store request channel.
- Uses a valid/ready request channel and a valid/ready response channel, so the M stage can stall on memory latency.
- Performs byte, half and word accesses, with sign- or zero-extension on reads and byte-lane merge on writes.
- Zeroes its own storage after reset with a hardware sweep.

Parameters:
- DEPTH_WORDS, 3072: storage size in 32-bit words (12 KB).
- ADDR_BASE, 32'h0000_0000: byte address that maps to word 0.
- LATENCY, 2: cycles from request accept edge to resp_valid rising; legal range 1..15.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; forces INIT.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  2  access size: DMOP_W, DMOP_H or DMOP_B.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bytes are used for H and B.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  pipeline consumes the response.
- resp_rdata  out  32  extended load data; 0 for stores and on errors.
- resp_err  out  1  misaligned or out-of-range access.

Behaviour:
- States: INIT, IDLE, WAIT, RESP. Encoding lives in the package.
- Reset values: state=INIT, sweep index=0, latency counter=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
- Reset asserted mid-operation: any pending request is dropped, resp_valid drops immediately, and the sweep restarts.
- INIT: writes 0 to word[idx] each cycle, idx 0..DEPTH_WORDS-1. After the last word, go to IDLE. INIT takes exactly DEPTH_WORDS cycles.
- IDLE: req_ready=1.
  - On an edge with req_valid=1, latch we/op/signed/addr/wdata and load counter=LATENCY-1.
  - If LATENCY=1, go to RESP; otherwise go to WAIT.
- WAIT: the counter decrements each cycle; when it reaches 1, go to RESP on that edge.
- Total latency: resp_valid rises exactly LATENCY cycles after the accept edge.
- Memory access happens on the edge that enters RESP:
  - The read result is captured into resp_rdata.
  - A store is committed on the same edge.
- Address check: off = addr - ADDR_BASE, computed in 32-bit unsigned arithmetic.
  - err if off >= DEPTH_WORDS*4.
  - err if op=W and off[1:0] != 0.
  - err if op=H and off[0] != 0.
  - On err: no write, resp_rdata=0, resp_err=1.
- Lanes are little-endian: byte k = bits [8k+7:8k], with k = off[1:0].
  - H uses lanes {off[1],0} and {off[1],1}.
- Store merge: only the addressed lanes change; the other lanes of the word keep their contents.
  - B writes wdata[7:0].
  - H writes wdata[15:0].
- Load extension: B/H results are zero- or sign-extended to 32 bits according to the latched signed bit. W ignores signed.
- Stores complete with resp_rdata=0 and resp_err per the address check.
- RESP: resp_valid=1, and resp_rdata/resp_err are held stable.
  - On an edge with resp_ready=1, go to IDLE and clear resp_valid.
  - req_ready is therefore 0 in the accept cycle; the next request can be accepted no earlier than the following cycle.
- resp_ready asserted while resp_valid=0 is ignored.
- req_valid asserted outside IDLE is ignored; the requester holds it.
- Word index = off[31:2]. The index is never wrapped; out-of-range addresses raise err instead.

Decomposition:
- Shared package dm_pkg:
  - DMOP_W=2'd0, DMOP_H=2'd1, DMOP_B=2'd2.
  - State encoding.
  - LATENCY counter width: 4 bits.
- Sub-module dm_lane_unit (combinational):
  - Inputs: op, signed, off[1:0], old word, wdata.
  - Outputs: merged store word and extended load value.
  - Instantiated once; the FSM and storage stay in dm_responder.

Test Plan:
- Reset, then hold with DEPTH_WORDS=16 → req_ready low for exactly 16 cycles after reset deasserts. A load of addr 0x3C then returns rdata=0, err=0.
- SW 0x8765_4321 @0x10, then LB signed @0x13, LBU @0x13, LH signed @0x12, LW @0x10 → rdata 0xFFFF_FF87, 0x0000_0087, 0xFFFF_8765, 0x8765_4321. Each resp_valid arrives exactly LATENCY=2 cycles after its accept.
- SW 0xAABB_CCDD @0x20, SB 0x11 @0x21, SH 0x2233 @0x22 → LW @0x20 returns 0x2233_11DD.
- LW @0x22, LH @0x21, and SW @DEPTH_WORDS*4 → each gives err=1, rdata=0; the memory word at 0x20 is unchanged.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and rdata stay stable and req_ready stays 0. Raising resp_ready gives IDLE on the next cycle.
- Assert reset during WAIT of a pending SW @0x4 → resp_valid stays 0 and the sweep reruns. A later LW @0x4 returns 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM
// encoding, latency counter width and the alignment rule.
package dm_pkg;

  localparam logic [1:0] DMOP_W = 2'd0;
  localparam logic [1:0] DMOP_H = 2'd1;
  localparam logic [1:0] DMOP_B = 2'd2;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } dm_state_e;

  // Alignment check on the low offset bits. The unused size code is
  // treated as an error so it can never write the array.
  function automatic logic dm_misaligned(input logic [1:0] op, input logic [1:0] off_lo);
    logic bad;
    case (op)
      DMOP_W:  bad = (off_lo != 2'b00);
      DMOP_H:  bad = off_lo[0];
      DMOP_B:  bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane steering: merges store data into the old word and extracts
// the sign/zero-extended load value. Little-endian lane order.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic        signed_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] store_word_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection, store merge and load extension.
  always_comb begin
    byte_sel     = old_word_i[{off_i, 3'b000} +: 8];
    half_sel     = off_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    store_word_o = old_word_i;
    load_data_o  = old_word_i;
    case (op_i)
      DMOP_W: begin
        store_word_o = wdata_i;
      end
      DMOP_H: begin
        store_word_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        load_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      end
      DMOP_B: begin
        store_word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        load_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the M-stage load/store channel.
//
// state | meaning
// INIT  | hardware sweep writing zero to every word, one per cycle
// IDLE  | req_ready high, waiting for a request
// WAIT  | latency counter running down
// RESP  | response presented, held until resp_ready
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_op,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned     IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]     SIZE_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

  dm_state_e        state_q;
  logic [IDX_W-1:0] sweep_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [1:0]       op_q;
  logic             sgn_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic [31:0]      resp_rdata_q;
  logic             resp_err_q;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             acc_we_d;
  logic [1:0]       acc_op_d;
  logic             acc_sgn_d;
  logic [31:0]      acc_addr_d;
  logic [31:0]      acc_wdata_d;
  logic [31:0]      off_d;
  logic             err_d;
  logic [IDX_W-1:0] widx_d;
  logic [31:0]      old_word_d;
  logic [31:0]      store_word_d;
  logic [31:0]      load_data_d;
  logic [31:0]      resp_rdata_d;
  logic             enter_resp_d;
  logic             mem_we_d;
  logic [IDX_W-1:0] mem_widx_d;
  logic [31:0]      mem_wdata_d;

  // With LATENCY=1 the access happens on the accept edge itself, so the
  // live request is used in IDLE and the latched copy everywhere else.
  always_comb begin
    acc_we_d    = we_q;
    acc_op_d    = op_q;
    acc_sgn_d   = sgn_q;
    acc_addr_d  = addr_q;
    acc_wdata_d = wdata_q;
    if (state_q == ST_IDLE) begin
      acc_we_d    = req_we;
      acc_op_d    = req_op;
      acc_sgn_d   = req_signed;
      acc_addr_d  = req_addr;
      acc_wdata_d = req_wdata;
    end
  end

  assign off_d        = acc_addr_d - ADDR_BASE;
  assign err_d        = (off_d >= SIZE_BYTES) | dm_misaligned(acc_op_d, off_d[1:0]);
  assign widx_d       = off_d[IDX_W+1:2];
  assign old_word_d   = mem_q[widx_d];
  assign resp_rdata_d = (acc_we_d | err_d) ? 32'd0 : load_data_d;

  dm_lane_unit u_lane (
    .op_i         (acc_op_d),
    .signed_i     (acc_sgn_d),
    .off_i        (off_d[1:0]),
    .old_word_i   (old_word_d),
    .wdata_i      (acc_wdata_d),
    .store_word_o (store_word_d),
    .load_data_o  (load_data_d)
  );

  // Flags the edge that enters RESP; the memory access happens on it.
  always_comb begin
    enter_resp_d = 1'b0;
    if (state_q == ST_IDLE && req_valid) begin
      enter_resp_d = (LATENCY == 1);
    end else if (state_q == ST_WAIT && cnt_q == CNT_W'(1)) begin
      enter_resp_d = 1'b1;
    end
  end

  // Array write port shared by the zeroing sweep and store commits.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_widx_d  = sweep_q;
    mem_wdata_d = 32'd0;
    if (state_q == ST_INIT) begin
      mem_we_d = 1'b1;
    end else if (enter_resp_d && acc_we_d && !err_d) begin
      mem_we_d    = 1'b1;
      mem_widx_d  = widx_d;
      mem_wdata_d = store_word_d;
    end
  end

  // Storage array, no reset: contents are cleared by the INIT sweep.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_widx_d] <= mem_wdata_d;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      op_q         <= DMOP_W;
      sgn_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (sweep_q == IDX_W'(DEPTH_WORDS - 1)) begin
            state_q     <= ST_IDLE;
            sweep_q     <= '0;
            req_ready_q <= 1'b1;
          end else begin
            sweep_q <= sweep_q + IDX_W'(1);
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            op_q        <= req_op;
            sgn_q       <= req_signed;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            cnt_q       <= CNT_LOAD;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= resp_rdata_d;
              resp_err_q   <= err_d;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed scenarios plus random traffic checked
// against a byte-addressed reference memory.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int unsigned DW   = 16;
  localparam int unsigned LAT  = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MB   = DW * 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_op;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mb [MB];

  dm_responder #(
    .DEPTH_WORDS (DW),
    .ADDR_BASE   (BASE),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_op     (req_op),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [1:0] op);
    if (op == DMOP_W) return 4;
    if (op == DMOP_H) return 2;
    return 1;
  endfunction

  function automatic logic m_err(input logic [1:0] op, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (off >= MB) return 1'b1;
    return (off % m_size(op)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] op, input logic sgn, input logic [31:0] addr);
    logic [31:0] off;
    logic [31:0] v;
    int nb;
    off = addr - BASE;
    nb  = m_size(op);
    v   = 32'd0;
    for (int i = 0; i < nb; i++) v = v | (32'(mb[off + i]) << (8 * i));
    if (nb < 4 && sgn && v[8 * nb - 1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
    return v;
  endfunction

  task automatic m_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] off;
    off = addr - BASE;
    for (int i = 0; i < m_size(op); i++) mb[off + i] = wd[8 * i +: 8];
  endtask

  task automatic m_clear();
    for (int i = 0; i < MB; i++) mb[i] = 8'h00;
  endtask

  // ---------------- stimulus helpers ----------------
  // Presents a request and returns at the negedge after the accept edge.
  task automatic start_req(input logic we, input logic [1:0] op, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd, output logic ok);
    int n;
    req_valid  = 1'b1;
    req_we     = we;
    req_op     = op;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic do_req(input logic we, input logic [1:0] op, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold);
    logic        e_err;
    logic [31:0] e_rd;
    logic        ok;
    int          lat;
    e_err = m_err(op, addr);
    e_rd  = (we || e_err) ? 32'd0 : m_load(op, sgn, addr);
    start_req(we, op, sgn, addr, wd, ok);
    if (!ok) return;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    check("rdata", resp_rdata, e_rd);
    check("err", 32'(resp_err), 32'(e_err));
    if (we && !e_err) m_store(op, addr, wd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, e_rd);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("release_valid", 32'(resp_valid), 32'd0);
    check("release_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    int n;
    reset      = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    #1;
    check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_err"}, 32'(resp_err), 32'd0);
    reset = 1'b0;
    m_clear();
    n = 0;
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_sweep_len"}, 32'(n), 32'(DW));
  endtask

  initial begin
    logic        ok;
    logic        we, sgn;
    logic [1:0]  op;
    logic [31:0] addr;
    int          n;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_op     = DMOP_W;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    m_clear();

    do_reset("por");
    do_req(1'b0, DMOP_W, 1'b0, 32'h3C, 32'd0, 0);

    do_req(1'b1, DMOP_W, 1'b0, 32'h10, 32'h8765_4321, 0);
    do_req(1'b0, DMOP_B, 1'b1, 32'h13, 32'd0, 0);
    do_req(1'b0, DMOP_B, 1'b0, 32'h13, 32'd0, 0);
    do_req(1'b0, DMOP_H, 1'b1, 32'h12, 32'd0, 0);
    do_req(1'b0, DMOP_W, 1'b0, 32'h10, 32'd0, 5);

    do_req(1'b1, DMOP_W, 1'b0, 32'h20, 32'hAABB_CCDD, 0);
    do_req(1'b1, DMOP_B, 1'b0, 32'h21, 32'hFFFF_FF11, 0);
    do_req(1'b1, DMOP_H, 1'b0, 32'h22, 32'hFFFF_2233, 0);
    do_req(1'b0, DMOP_W, 1'b0, 32'h20, 32'd0, 0);

    do_req(1'b0, DMOP_W, 1'b0, 32'h22, 32'd0, 0);
    do_req(1'b0, DMOP_H, 1'b1, 32'h21, 32'd0, 0);
    do_req(1'b1, DMOP_W, 1'b0, MB, 32'hDEAD_BEEF, 0);
    do_req(1'b1, DMOP_B, 1'b0, 32'h21, 32'd0, 0);
    do_req(1'b1, DMOP_W, 1'b0, 32'h23, 32'h0BAD_0BAD, 0);
    do_req(1'b0, DMOP_W, 1'b0, 32'h20, 32'd0, 1);

    do_req(1'b1, DMOP_W, 1'b0, 32'h4, 32'h5A5A_5A5A, 0);
    do_req(1'b0, DMOP_W, 1'b0, 32'h4, 32'd0, 0);
    start_req(1'b1, DMOP_W, 1'b0, 32'h4, 32'h1234_5678, ok);
    check("wait_no_valid", 32'(resp_valid), 32'd0);
    do_reset("rst_wait");
    do_req(1'b0, DMOP_W, 1'b0, 32'h4, 32'd0, 0);

    do_req(1'b1, DMOP_H, 1'b0, 32'h8, 32'h0000_9ABC, 0);
    start_req(1'b0, DMOP_H, 1'b1, 32'h8, 32'd0, ok);
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resp_before_reset", 32'(resp_valid), 32'd1);
    do_reset("rst_resp");
    do_req(1'b0, DMOP_H, 1'b0, 32'h8, 32'd0, 0);

    for (int i = 0; i < 150; i++) begin
      op   = 2'($urandom_range(0, 2));
      we   = 1'($urandom_range(0, 1));
      sgn  = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MB + 3));
      if (op == DMOP_W && $urandom_range(0, 3) != 0) addr = addr & ~32'd3;
      if (op == DMOP_H && $urandom_range(0, 3) != 0) addr = addr & ~32'd1;
      do_req(we, op, sgn, addr, $urandom, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
